// File: rtl/global_buffer_pkg.sv
// global_buffer_pkg: GLB widths, packet and header types.
// Shared by the load DMA top and its lane pipe.
package global_buffer_pkg;

  localparam int GLB_ADDR_WIDTH      = 22;
  localparam int BANK_DATA_WIDTH     = 64;
  localparam int CGRA_DATA_WIDTH     = 16;
  localparam int MAX_NUM_WORDS_WIDTH = 21;
  localparam int RD_LATENCY          = 2;
  localparam int LANE_WIDTH          = 2;

  typedef struct packed {
    logic                           valid;
    logic [GLB_ADDR_WIDTH-1:0]      start_addr;
    logic [MAX_NUM_WORDS_WIDTH-1:0] num_words;
    logic                           inactive_on;
    logic [MAX_NUM_WORDS_WIDTH-1:0] num_active_words;
    logic [MAX_NUM_WORDS_WIDTH-1:0] num_inactive_words;
    logic                           repeat_on;
  } dma_ld_header_t;

  typedef struct packed {
    logic                      rd_en;
    logic [GLB_ADDR_WIDTH-1:0] rd_addr;
  } rdrq_packet_t;

  typedef struct packed {
    logic [BANK_DATA_WIDTH-1:0] rd_data;
    logic                       rd_data_valid;
  } rdrs_packet_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    INACTIVE,
    DRAIN
  } ld_dma_state_e;

endpackage

// File: rtl/glb_ld_dma_pipe.sv
// glb_ld_dma_pipe: DEPTH-stage {valid, lane} shift pipe.
// Aligns issued word lanes with the bank read response.
module glb_ld_dma_pipe
  import global_buffer_pkg::*;
#(
  parameter int DEPTH = RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_vld,
  input  logic [LANE_WIDTH-1:0] i_lane,
  output logic                  o_vld,
  output logic [LANE_WIDTH-1:0] o_lane
);

  logic [DEPTH-1:0]                 r_vld;
  logic [DEPTH-1:0][LANE_WIDTH-1:0] r_lane;

  // shift issued lanes toward the response side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_lane <= '0;
    end else begin
      r_vld[0]  <= i_vld;
      r_lane[0] <= i_lane;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_lane[i] <= r_lane[i-1];
      end
    end
  end

  assign o_vld  = r_vld[DEPTH-1];
  assign o_lane = r_lane[DEPTH-1];

endmodule

// File: rtl/glb_ld_dma.sv
// glb_ld_dma: GLB load DMA, line reads unpacked to 16-bit stream.
// Optional macro GLB_LD_DMA_PERF_CNT_EN adds perf_inactive_cycles.
module glb_ld_dma
  import global_buffer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  dma_ld_header_t             ld_header,
  input  logic                       start_pulse,
  input  logic                       stop_pulse,
  output rdrq_packet_t               rdrq,
  input  rdrs_packet_t               rdrs,
  output logic [CGRA_DATA_WIDTH-1:0] stream_data,
  output logic                       stream_valid,
  output logic                       busy,
  output logic                       done_pulse
`ifdef GLB_LD_DMA_PERF_CNT_EN
  ,
  output logic [31:0]                perf_inactive_cycles
`endif
);

  localparam int CW = MAX_NUM_WORDS_WIDTH;

  ld_dma_state_e              r_state;
  ld_dma_state_e              w_next;
  dma_ld_header_t             r_hdr;
  logic [CW-1:0]              r_word_cnt;
  logic [CW-1:0]              r_run_cnt;
  logic [CW-1:0]              r_wait_cnt;
  logic                       r_first;
  logic                       r_done;
  logic [BANK_DATA_WIDTH-1:0] r_line;

  logic [CW-1:0]              w_waddr;
  logic [LANE_WIDTH-1:0]      w_lane;
  logic [CW-1:0]              w_cnt_nxt;
  logic [CW-1:0]              w_run_nxt;
  logic [CW-1:0]              w_inact_len;
  logic                       w_issue;
  logic                       w_last;
  logic                       w_run_end;
  logic                       w_inact_end;
  logic                       w_start_ok;
  logic                       w_done_set;
  logic                       w_pvld;
  logic [LANE_WIDTH-1:0]      w_plane;
  logic [BANK_DATA_WIDTH-1:0] w_src;
  logic                       w_unused_bits;

  assign w_waddr     = r_hdr.start_addr[GLB_ADDR_WIDTH-1:1] + r_word_cnt;
  assign w_lane      = w_waddr[LANE_WIDTH-1:0];
  assign w_cnt_nxt   = r_word_cnt + CW'(1);
  assign w_run_nxt   = r_run_cnt + CW'(1);
  assign w_issue     = (r_state == ACTIVE) && !stop_pulse;
  assign w_last      = (w_cnt_nxt == r_hdr.num_words);
  assign w_run_end   = r_hdr.inactive_on &&
                       (w_run_nxt == r_hdr.num_active_words);
  assign w_inact_len = (r_hdr.num_inactive_words == '0) ?
                       CW'(1) : r_hdr.num_inactive_words;
  assign w_inact_end = (r_wait_cnt + CW'(1)) >= w_inact_len;
  assign w_start_ok  = start_pulse && ld_header.valid &&
                       (ld_header.num_words != '0);
  assign w_done_set  = ((r_state == IDLE) && start_pulse &&
                        ld_header.valid && (ld_header.num_words == '0)) ||
                       ((r_state == DRAIN) && (w_next == IDLE));
  assign w_unused_bits = ^{r_hdr.valid, r_hdr.start_addr[0]};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next-state: stop always forces DRAIN outside IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start_ok) w_next = ACTIVE;
      end
      ACTIVE: begin
        if (stop_pulse)     w_next = DRAIN;
        else if (w_last)    w_next = r_hdr.repeat_on ? ACTIVE : DRAIN;
        else if (w_run_end) w_next = INACTIVE;
      end
      INACTIVE: begin
        if (stop_pulse)       w_next = DRAIN;
        else if (w_inact_end) w_next = ACTIVE;
      end
      DRAIN: begin
        if (!stop_pulse && r_wait_cnt == CW'(RD_LATENCY - 1))
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // header latch, word/run/wait counters, line register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr      <= '0;
      r_word_cnt <= '0;
      r_run_cnt  <= '0;
      r_wait_cnt <= '0;
      r_first    <= 1'b0;
      r_done     <= 1'b0;
      r_line     <= '0;
    end else begin
      r_done <= w_done_set;
      if (rdrs.rd_data_valid) r_line <= rdrs.rd_data;
      if (r_state != w_next || stop_pulse)
        r_wait_cnt <= '0;
      else if (r_state == INACTIVE || r_state == DRAIN)
        r_wait_cnt <= r_wait_cnt + CW'(1);
      if (r_state == IDLE) begin
        if (w_start_ok) begin
          r_hdr      <= ld_header;
          r_word_cnt <= '0;
          r_run_cnt  <= '0;
          r_first    <= 1'b1;
        end
      end else if (w_issue) begin
        if (w_last && r_hdr.repeat_on) begin
          r_word_cnt <= '0;
          r_run_cnt  <= '0;
          r_first    <= 1'b1;
        end else begin
          r_word_cnt <= w_cnt_nxt;
          r_run_cnt  <= w_run_end ? '0 : w_run_nxt;
          r_first    <= w_run_end;
        end
      end
    end
  end

  // read a line on the first word of a run or at lane 0
  always_comb begin
    rdrq = '0;
    if (w_issue && (r_first || w_lane == '0)) begin
      rdrq.rd_en   = 1'b1;
      rdrq.rd_addr = {w_waddr[CW-1:2], 3'b000};
    end
  end

  glb_ld_dma_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (w_issue),
    .i_lane (w_lane),
    .o_vld  (w_pvld),
    .o_lane (w_plane)
  );

  assign w_src = rdrs.rd_data_valid ? rdrs.rd_data : r_line;

  // lane slice of the current line, zero when no word is due
  always_comb begin
    stream_data = '0;
    if (w_pvld) stream_data = w_src[{w_plane, 4'b0000} +: CGRA_DATA_WIDTH];
  end

  assign stream_valid = w_pvld;
  assign busy         = (r_state != IDLE);
  assign done_pulse   = r_done;

`ifdef GLB_LD_DMA_PERF_CNT_EN
  logic [31:0] r_perf;

  // saturating INACTIVE cycle count since the last start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_perf <= '0;
    else if (r_state == IDLE && start_pulse)
      r_perf <= '0;
    else if (r_state == INACTIVE && r_perf != '1)
      r_perf <= r_perf + 32'd1;
  end

  assign perf_inactive_cycles = r_perf;
`endif

endmodule

// File: tb/tb_glb_ld_dma.sv
// tb_glb_ld_dma: directed checks of glb_ld_dma against a
// fixed-latency bank model whose words equal their byte address.
module tb_glb_ld_dma;
  import global_buffer_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  dma_ld_header_t ld_header = '0;
  dma_ld_header_t alt_hdr;
  logic           start_pulse = 1'b0;
  logic           stop_pulse = 1'b0;
  rdrq_packet_t   rdrq;
  rdrs_packet_t   rdrs;
  logic [15:0]    stream_data;
  logic           stream_valid;
  logic           busy;
  logic           done_pulse;
`ifdef GLB_LD_DMA_PERF_CNT_EN
  logic [31:0]    perf;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] exp_dat[$];
  logic [21:0] exp_adr[$];

  always #5 clk = ~clk;

  glb_ld_dma dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_header    (ld_header),
    .start_pulse  (start_pulse),
    .stop_pulse   (stop_pulse),
    .rdrq         (rdrq),
    .rdrs         (rdrs),
    .stream_data  (stream_data),
    .stream_valid (stream_valid),
    .busy         (busy),
    .done_pulse   (done_pulse)
`ifdef GLB_LD_DMA_PERF_CNT_EN
    ,
    .perf_inactive_cycles (perf)
`endif
  );

  rdrq_packet_t m_q [RD_LATENCY];
  logic [15:0]  m_a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) m_q[i] <= '0;
    end else begin
      m_q[0] <= rdrq;
      for (int i = 1; i < RD_LATENCY; i++) m_q[i] <= m_q[i-1];
    end
  end

  assign m_a = m_q[RD_LATENCY-1].rd_addr[15:0];
  assign rdrs.rd_data = {m_a + 16'd6, m_a + 16'd4, m_a + 16'd2, m_a};
  assign rdrs.rd_data_valid = m_q[RD_LATENCY-1].rd_en;

  function automatic dma_ld_header_t hdr(
    input logic [21:0] a, input logic [20:0] n, input logic io,
    input logic [20:0] na, input logic [20:0] ni, input logic rp,
    input logic v);
    dma_ld_header_t h;
    h.valid = v;
    h.start_addr = a;
    h.num_words = n;
    h.inactive_on = io;
    h.num_active_words = na;
    h.num_inactive_words = ni;
    h.repeat_on = rp;
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done_pulse), 32'd0);
    chk({tag, ".vld"}, 32'(stream_valid), 32'd0);
    chk({tag, ".data"}, 32'(stream_data), 32'd0);
    chk({tag, ".rden"}, 32'(rdrq.rd_en), 32'd0);
    chk({tag, ".radr"}, 32'(rdrq.rd_addr), 32'd0);
  endtask

  task automatic start(input dma_ld_header_t h, input logic stp);
    @(posedge clk); #1;
    ld_header = h;
    start_pulse = 1'b1;
    stop_pulse = stp;
    #1;
    chk("start.busy", 32'(busy), 32'd0);
  endtask

  task automatic watch(input string nm, input int n,
                       input logic [31:0] ev, input logic [31:0] ee,
                       input logic [31:0] ed, input logic [31:0] eb,
                       input int stop_at, input int start_at);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start_pulse = (i == start_at);
      if (i == start_at) ld_header = alt_hdr;
      stop_pulse = (i == stop_at);
      #1;
      chk($sformatf("%s[%0d].vld", nm, i),
          32'(stream_valid), 32'(ev[n-1-i]));
      chk($sformatf("%s[%0d].rden", nm, i),
          32'(rdrq.rd_en), 32'(ee[n-1-i]));
      chk($sformatf("%s[%0d].done", nm, i),
          32'(done_pulse), 32'(ed[n-1-i]));
      chk($sformatf("%s[%0d].busy", nm, i),
          32'(busy), 32'(eb[n-1-i]));
      if (ev[n-1-i])
        chk($sformatf("%s[%0d].data", nm, i),
            32'(stream_data), 32'(exp_dat.pop_front()));
      if (ee[n-1-i])
        chk($sformatf("%s[%0d].radr", nm, i),
            32'(rdrq.rd_addr), 32'(exp_adr.pop_front()));
    end
    start_pulse = 1'b0;
    stop_pulse = 1'b0;
  endtask

  initial begin
    alt_hdr = hdr(22'h400, 21'd2, 1'b0, 21'd0, 21'd0, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // basic aligned read of 8 words
    start(hdr(22'h100, 21'd8, 1'b0, 21'd0, 21'd0, 1'b0, 1'b1), 1'b0);
    for (int k = 0; k < 8; k++) exp_dat.push_back(16'(16'h100 + 2*k));
    exp_adr.push_back(22'h100);
    exp_adr.push_back(22'h108);
    watch("basic", 12, 12'b001111111100, 12'b100010000000,
          12'b000000000010, 12'b111111111100, -1, -1);

    // unaligned start, simultaneous stop in IDLE loses to start
    start(hdr(22'h106, 21'd3, 1'b0, 21'd0, 21'd0, 1'b0, 1'b1), 1'b1);
    exp_dat.push_back(16'h106);
    exp_dat.push_back(16'h108);
    exp_dat.push_back(16'h10A);
    exp_adr.push_back(22'h100);
    exp_adr.push_back(22'h108);
    watch("unal", 7, 7'b0011100, 7'b1100000,
          7'b0000010, 7'b1111100, -1, -1);

    // duty cycle 2 on / 3 off, with an ignored start while busy
    start(hdr(22'h200, 21'd6, 1'b1, 21'd2, 21'd3, 1'b0, 1'b1), 1'b0);
    for (int k = 0; k < 6; k++) exp_dat.push_back(16'(16'h200 + 2*k));
    exp_adr.push_back(22'h200);
    exp_adr.push_back(22'h200);
    exp_adr.push_back(22'h208);
    watch("duty", 16, 16'b0011000110001100, 16'b1000010000100000,
          16'b0000000000000010, 16'b1111111111111100, -1, 3);
`ifdef GLB_LD_DMA_PERF_CNT_EN
    chk("perf", perf, 32'd6);
`endif

    // repeat mode, stopped at cycle 10
    start(hdr(22'h300, 21'd4, 1'b0, 21'd0, 21'd0, 1'b1, 1'b1), 1'b0);
    for (int k = 0; k < 10; k++)
      exp_dat.push_back(16'(16'h300 + 2*(k % 4)));
    for (int k = 0; k < 3; k++) exp_adr.push_back(22'h300);
    watch("rept", 15, 15'b001111111111000, 15'b100010001000000,
          15'b000000000000010, 15'b111111111111100, 10, -1);

    // zero words: done only
    start(hdr(22'h500, 21'd0, 1'b0, 21'd0, 21'd0, 1'b0, 1'b1), 1'b0);
    watch("zero", 4, 4'b0000, 4'b0000, 4'b1000, 4'b0000, -1, -1);

    // header not valid: ignored
    start(hdr(22'h500, 21'd4, 1'b0, 21'd0, 21'd0, 1'b0, 1'b0), 1'b0);
    watch("inval", 3, 3'b000, 3'b000, 3'b000, 3'b000, -1, -1);

    // async reset in the middle of ACTIVE
    start(hdr(22'h100, 21'd8, 1'b0, 21'd0, 21'd0, 1'b0, 1'b1), 1'b0);
    exp_dat.push_back(16'h100);
    exp_adr.push_back(22'h100);
    watch("pre_rst", 3, 3'b001, 3'b100, 3'b000, 3'b111, -1, -1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    watch("post_rst", 4, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/glb_ld_dma.md
Name: glb_ld_dma

Overview:
- Load-side DMA for one GLB tile; the reader counterpart of the store DMA.
- Takes a dma_ld_header_t, issues rdrq_packet_t line reads to the tile's banks, and consumes the returned rdrs_packet_t.
- Unpacks each 64-bit line into 16-bit words and streams them to the CGRA column pair, honouring the active/inactive duty cycle and repeat mode.

Parameters:
- GLB_ADDR_WIDTH, 22, byte address width (bank 17 + bank sel 1 + tile sel 4).
- BANK_DATA_WIDTH, 64, SRAM line width.
- CGRA_DATA_WIDTH, 16, streamed word width.
- MAX_NUM_WORDS_WIDTH, 21, word-count field width.
- RD_LATENCY, 2, fixed cycles from rdrq issue to rdrs.rd_data_valid; minimum 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ld_header  in  dma_ld_header_t  programmed header; sampled on start_pulse
- start_pulse  in  1  one-cycle start strobe
- stop_pulse  in  1  abort current or repeating transfer
- rdrq  out  rdrq_packet_t  line read request; rd_addr is 8-byte aligned
- rdrs  in  rdrs_packet_t  read response
- stream_data  out  16  word to CGRA
- stream_valid  out  1  stream_data qualifier; no backpressure
- busy  out  1  high in any non-IDLE state
- done_pulse  out  1  one cycle when a non-repeat transfer completes or a stop takes effect

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and line register cleared.
- start_pulse in IDLE with ld_header.valid=1 and num_words!=0 latches the header and enters ACTIVE next cycle. Otherwise start is ignored; a start with num_words=0 produces done_pulse one cycle later. start_pulse while busy is ignored.
- Word address: waddr = start_addr[21:1] + word_cnt. lane = waddr[1:0]. Line byte address = {waddr[20:2], 3'b000}.
- ACTIVE generates one word per cycle and increments word_cnt and run_cnt.
  - rdrq.rd_en=1 on the first word after entering ACTIVE, or when lane==0; rd_addr is the line address.
  - The same registered cycle also pushes {valid, lane} into an RD_LATENCY-deep pipe.
- Inactive handling, when inactive_on=1: after num_active_words words (run_cnt hits it), go to INACTIVE for num_inactive_words cycles, then return to ACTIVE. No reads are issued and the address does not advance. num_inactive_words=0 is treated as 1.
- When inactive_on=0, the run limit is ignored.
- Completion: after word number num_words is issued, go to DRAIN for RD_LATENCY cycles.
  - repeat_on=0: return to IDLE with done_pulse.
  - repeat_on=1: word_cnt reloads to 0 and ACTIVE resumes immediately, with no DRAIN and no done_pulse.
- Output path: the line register loads rdrs.rd_data when rd_data_valid=1.
  - stream_data = lane slice of (rd_data_valid ? rdrs.rd_data : line register), selected by the pipe-out lane. The slice is bits [16*lane+15 : 16*lane].
  - stream_valid = pipe-out valid. Stream latency from word issue is exactly RD_LATENCY cycles.
- stop_pulse: any state goes to DRAIN immediately, then IDLE with done_pulse. Words already in the pipe still emerge. stop_pulse in IDLE has no effect.
- Simultaneous start_pulse and stop_pulse in IDLE: start wins.
- Address wrap: waddr wraps modulo 2^21 with no error.
- Asynchronous reset mid-transfer clears everything; no done_pulse is generated.

Optional Feature:
- Macro GLB_LD_DMA_PERF_CNT_EN.
  - Defined: adds output port perf_inactive_cycles, 32 bits. It counts INACTIVE cycles since the last start_pulse, saturates at all-ones, and holds its value after done_pulse.
  - Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package global_buffer_pkg holds dma_ld_header_t, rdrq_packet_t, rdrs_packet_t, the width constants above, and a new enum ld_dma_state_e (IDLE, ACTIVE, INACTIVE, DRAIN).
- One sub-module, glb_ld_dma_pipe: the parameterised RD_LATENCY-deep {valid, lane} shift pipe with synchronous flush disabled. Reset is asynchronous only.

Test Plan:
- Basic, start_addr=0x100, num_words=8, no inactive, no repeat:
  - rdrq at 0x100 then 0x108, 4 cycles apart.
  - 8 consecutive stream_valid beats, data lanes 0..3 of each line.
  - done_pulse at issue+8+RD_LATENCY.
- Unaligned, start_addr=0x106, num_words=3:
  - rdrq at 0x100 (lane 3), then 0x108.
  - Outputs: line0[63:48], line1[15:0], line1[31:16].
- Duty cycle, num_words=6, inactive_on=1, active=2, inactive=3:
  - valid pattern 11000110001 1.
  - No rdrq during gaps.
- Repeat, num_words=4, repeat_on=1:
  - Continuous valid with rdrq at the same line every 4 cycles.
  - stop_pulse at cycle 10 gives done_pulse RD_LATENCY+1 cycles later.
  - busy stays high until then.
- Edge:
  - num_words=0 start gives done_pulse only, no rdrq.
  - start during busy is ignored.
  - rst_n low mid-ACTIVE gives all outputs 0 immediately.
- Perf counter (macro on), inactive=3 over 2 gaps: perf_inactive_cycles=6 after done_pulse.
